// File: rtl/axi_stream_strip_header.sv
// -----------------------------------------------------------------------------
// axi_stream_strip_header
//
// Removes the first H header bytes of every AXI Stream packet and emits them
// as one right-aligned beat on a separate header channel. The remaining
// payload bytes are re-packed MSB-first with no gaps. H is taken per packet
// from a one-beat length sideband and is saturated to the beat width.
//
// Optional feature (macro STRIP_HDR_ERR_EN):
//   adds err_short_o, a one-cycle pulse when a packet shorter than H
//   is accepted. Packet handling is the same with or without it.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   s_len_tvalid/tdata/tready   header length sideband (one beat per packet)
//   s_axis_*                    input stream (tkeep MSB-first contiguous)
//   m_hdr_*                     header beat, bytes right-aligned, tkeep low ones
//   m_axis_*                    payload stream, MSB-first packed
//   err_short_o                 short-packet pulse (STRIP_HDR_ERR_EN only)
//
// Handshake: a transfer happens on a rising clock edge where tvalid and
// tready are both high; a source holds tdata/tkeep/tlast stable while
// tvalid is high and tready is low, and tvalid never depends on tready.
// -----------------------------------------------------------------------------
module axi_stream_strip_header #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int LEN_WD       = $clog2(DATA_BYTE_WD + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    s_len_tvalid,
   input  logic [LEN_WD-1:0]       s_len_tdata,
   output logic                    s_len_tready,
   input  logic                    s_axis_tvalid,
   input  logic [DATA_WD-1:0]      s_axis_tdata,
   input  logic [DATA_BYTE_WD-1:0] s_axis_tkeep,
   input  logic                    s_axis_tlast,
   output logic                    s_axis_tready,
   output logic                    m_hdr_tvalid,
   output logic [DATA_WD-1:0]      m_hdr_tdata,
   output logic [DATA_BYTE_WD-1:0] m_hdr_tkeep,
   input  logic                    m_hdr_tready,
   output logic                    m_axis_tvalid,
   output logic [DATA_WD-1:0]      m_axis_tdata,
   output logic [DATA_BYTE_WD-1:0] m_axis_tkeep,
   output logic                    m_axis_tlast,
   input  logic                    m_axis_tready
`ifdef STRIP_HDR_ERR_EN
   ,
   output logic                    err_short_o
`endif
);

   localparam int W = DATA_BYTE_WD;

   typedef enum logic [1:0] {IDLE, FIRST, BODY, FLUSH} state_t;

   state_t state, state_next;

   logic                len_rdy;
   logic [LEN_WD-1:0]   hlen;      // saturated header length of current packet
   logic [DATA_WD-1:0]  res_data;  // leftover bytes of previous beat, left-aligned
   logic [LEN_WD-1:0]   res_cnt;   // leftover byte count for the flush beat
   logic [LEN_WD-1:0]   in_cnt, hk, rr, hsh;
   logic                out_free, in_hs, len_hs;

   logic                out_load, out_last_n, res_load, hdr_load;
   logic [DATA_WD-1:0]  out_data_n, res_data_n, hdr_data_n;
   logic [LEN_WD-1:0]   out_cnt_n, res_cnt_n, hdr_cnt_n;
`ifdef STRIP_HDR_ERR_EN
   logic                short_pkt;
`endif

   function automatic logic [LEN_WD-1:0] keep_count(input logic [W-1:0] keep);
      logic [LEN_WD-1:0] c;
      c = '0;
      for (int i = 0; i < W; i++)
         if (keep[i]) c = c + LEN_WD'(1);
      return c;
   endfunction

   function automatic logic [W-1:0] msb_mask(input logic [LEN_WD-1:0] n);
      logic [W-1:0] m;
      m = '0;
      for (int i = 0; i < W; i++) m[W-1-i] = (i < int'(n));
      return m;
   endfunction

   function automatic logic [W-1:0] lsb_mask(input logic [LEN_WD-1:0] n);
      logic [W-1:0] m;
      m = '0;
      for (int i = 0; i < W; i++) m[i] = (i < int'(n));
      return m;
   endfunction

   function automatic logic [DATA_WD-1:0] byte_mask(input logic [W-1:0] keep);
      logic [DATA_WD-1:0] bm;
      bm = '0;
      for (int i = 0; i < W; i++) bm[8*i +: 8] = {8{keep[i]}};
      return bm;
   endfunction

   assign in_cnt   = keep_count(s_axis_tkeep);
   assign hk       = (in_cnt < hlen) ? in_cnt : hlen;  // header bytes present in this beat
   assign rr       = LEN_WD'(W) - hlen;                  // residual bytes carried per beat
   assign hsh      = LEN_WD'(W) - hk;                    // right-align shift for header
   assign out_free = !m_axis_tvalid || m_axis_tready;

   assign s_len_tready  = len_rdy;
   assign s_axis_tready = ((state == FIRST) && !m_hdr_tvalid && out_free) ||
                          ((state == BODY) && out_free);
   assign in_hs  = s_axis_tvalid && s_axis_tready;
   assign len_hs = s_len_tvalid && len_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         len_rdy <= 1'b0;
      end else begin
         state   <= state_next;
         // Registered so the length port stays low while reset is applied.
         len_rdy <= (state_next == IDLE);
      end
   end

   always_comb begin
      state_next = state;
      out_load   = 1'b0;
      out_data_n = '0;
      out_cnt_n  = '0;
      out_last_n = 1'b0;
      res_load   = 1'b0;
      res_data_n = res_data;
      res_cnt_n  = res_cnt;
      hdr_load   = 1'b0;
      hdr_data_n = '0;
      hdr_cnt_n  = '0;
`ifdef STRIP_HDR_ERR_EN
      short_pkt  = 1'b0;
`endif
      case (state)
         IDLE: if (len_hs) state_next = FIRST;
         FIRST: if (in_hs) begin
            hdr_load   = (hlen != '0);
            hdr_data_n = s_axis_tdata >> {hsh, 3'b000};
            hdr_cnt_n  = hk;
            res_load   = 1'b1;
            res_data_n = s_axis_tdata << {hlen, 3'b000};
            if (s_axis_tlast) begin
               state_next = IDLE;
               if (in_cnt > hlen) begin
                  out_load   = 1'b1;
                  out_data_n = s_axis_tdata << {hlen, 3'b000};
                  out_cnt_n  = in_cnt - hlen;
                  out_last_n = 1'b1;
               end
`ifdef STRIP_HDR_ERR_EN
               short_pkt = (in_cnt < hlen);
`endif
            end else begin
               state_next = BODY;
            end
         end
         BODY: if (in_hs) begin
            // Residual bytes fill the top of the word, the head of this beat the rest.
            out_load   = 1'b1;
            out_data_n = res_data | (s_axis_tdata >> {rr, 3'b000});
            out_cnt_n  = rr + hk;
            res_load   = 1'b1;
            res_data_n = s_axis_tdata << {hlen, 3'b000};
            if (s_axis_tlast) begin
               if (in_cnt > hlen) begin
                  res_cnt_n  = in_cnt - hlen;
                  state_next = FLUSH;
               end else begin
                  out_last_n = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         FLUSH: if (out_free) begin
            out_load   = 1'b1;
            out_data_n = res_data;
            out_cnt_n  = res_cnt;
            out_last_n = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hlen          <= '0;
         res_data      <= '0;
         res_cnt       <= '0;
         m_hdr_tvalid  <= 1'b0;
         m_hdr_tdata   <= '0;
         m_hdr_tkeep   <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tlast  <= 1'b0;
      end else begin
         if (len_hs)
            hlen <= (s_len_tdata > LEN_WD'(W)) ? LEN_WD'(W) : s_len_tdata;
         if (res_load) begin
            res_data <= res_data_n;
            res_cnt  <= res_cnt_n;
         end
         if (hdr_load) begin
            m_hdr_tvalid <= 1'b1;
            m_hdr_tdata  <= hdr_data_n;
            m_hdr_tkeep  <= lsb_mask(hdr_cnt_n);
         end else if (m_hdr_tready) begin
            m_hdr_tvalid <= 1'b0;
         end
         if (out_load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= out_data_n & byte_mask(msb_mask(out_cnt_n));
            m_axis_tkeep  <= msb_mask(out_cnt_n);
            m_axis_tlast  <= out_last_n;
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

`ifdef STRIP_HDR_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_short_o <= 1'b0;
      else        err_short_o <= short_pkt;
   end
`endif

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// -----------------------------------------------------------------------------
// tb_axi_stream_strip_header
//
// Directed packets with hand-computed results, then randomised packets with
// random sink back-pressure. A byte-level packet model builds the expected
// header and payload beats; one monitor compares every accepted output beat
// and checks that stalled outputs hold steady.
// -----------------------------------------------------------------------------
module tb_axi_stream_strip_header;

   localparam int W  = 4;
   localparam int DW = 32;
   localparam int LW = 3;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic           s_len_tvalid = 1'b0;
   logic [LW-1:0]  s_len_tdata = '0;
   logic           s_len_tready;
   logic           s_axis_tvalid = 1'b0;
   logic [DW-1:0]  s_axis_tdata = '0;
   logic [W-1:0]   s_axis_tkeep = '0;
   logic           s_axis_tlast = 1'b0;
   logic           s_axis_tready;
   logic           m_hdr_tvalid;
   logic [DW-1:0]  m_hdr_tdata;
   logic [W-1:0]   m_hdr_tkeep;
   logic           m_hdr_tready = 1'b1;
   logic           m_axis_tvalid;
   logic [DW-1:0]  m_axis_tdata;
   logic [W-1:0]   m_axis_tkeep;
   logic           m_axis_tlast;
   logic           m_axis_tready = 1'b1;
`ifdef STRIP_HDR_ERR_EN
   logic           err_short_o;
`endif

   axi_stream_strip_header #(.DATA_WD(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_len_tvalid(s_len_tvalid), .s_len_tdata(s_len_tdata), .s_len_tready(s_len_tready),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .m_hdr_tvalid(m_hdr_tvalid), .m_hdr_tdata(m_hdr_tdata), .m_hdr_tkeep(m_hdr_tkeep),
      .m_hdr_tready(m_hdr_tready),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
`ifdef STRIP_HDR_ERR_EN
      , .err_short_o(err_short_o)
`endif
   );

   // scoreboard
   logic [W+DW-1:0] exp_hdr_q[$];   // {keep, data}
   logic [W+DW:0]   exp_pay_q[$];   // {last, keep, data}
   logic [7:0]      pkt_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int exp_short = 0;
   int got_short = 0;
   bit rand_ready = 1'b0;
   bit hdr_block = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] bmask(input logic [W-1:0] k);
      logic [DW-1:0] m;
      m = '0;
      for (int i = 0; i < W; i++) if (k[i]) m[8*i +: 8] = 8'hFF;
      return m;
   endfunction

   // Expected outputs: first min(H,W) bytes form the header, the rest are
   // cut into W-byte payload beats.
   task automatic model_pkt(input int h);
      int n, he, hk;
      logic [DW-1:0] d;
      logic [W-1:0]  k;
      n  = pkt_q.size();
      he = (h > W) ? W : h;
      if (he > 0) begin
         hk = (n < he) ? n : he;
         d = '0;
         for (int i = 0; i < hk; i++) d = {d[DW-9:0], pkt_q[i]};
         k = '0;
         for (int i = 0; i < hk; i++) k[i] = 1'b1;
         exp_hdr_q.push_back({k, d});
      end
      if (n < he) exp_short++;
      for (int s = he; s < n; s += W) begin
         d = '0;
         k = '0;
         for (int j = 0; j < W; j++)
            if (s + j < n) begin
               d[DW-1-8*j -: 8] = pkt_q[s+j];
               k[W-1-j] = 1'b1;
            end
         exp_pay_q.push_back({(s + W >= n), k, d});
      end
   endtask

   // driver tasks (entered and left just after a rising edge)
   task automatic drive_len(input int h);
      bit hs;
      int cnt;
      hs = 1'b0;
      cnt = 0;
      s_len_tdata = LW'(h);
      s_len_tvalid = 1'b1;
      while (!hs && cnt < 2000) begin
         @(negedge clk);
         hs = s_len_tready;
         @(posedge clk);
         #1;
         cnt++;
      end
      s_len_tvalid = 1'b0;
      if (!hs) chk("len_timeout", hs, 1);
   endtask

   task automatic drive_beat(input logic [DW-1:0] d, input logic [W-1:0] k, input logic l);
      bit hs;
      int cnt;
      hs = 1'b0;
      cnt = 0;
      s_axis_tdata = d;
      s_axis_tkeep = k;
      s_axis_tlast = l;
      s_axis_tvalid = 1'b1;
      while (!hs && cnt < 2000) begin
         @(negedge clk);
         hs = s_axis_tready;
         @(posedge clk);
         #1;
         cnt++;
      end
      s_axis_tvalid = 1'b0;
      if (!hs) chk("beat_timeout", hs, 1);
   endtask

   // Unused byte lanes of the last beat carry random junk on purpose.
   task automatic drive_pkt(input int h, input int nbeats_max);
      logic [DW-1:0] d;
      logic [W-1:0]  k;
      int n, b;
      n = pkt_q.size();
      b = 0;
      drive_len(h);
      for (int s = 0; s < n && b < nbeats_max; s += W) begin
         d = $urandom;
         k = '0;
         for (int j = 0; j < W; j++)
            if (s + j < n) begin
               d[DW-1-8*j -: 8] = pkt_q[s+j];
               k[W-1-j] = 1'b1;
            end
         drive_beat(d, k, (s + W >= n));
         b++;
      end
   endtask

   task automatic run_pkt(input int h);
      model_pkt(h);
      drive_pkt(h, 1000);
   endtask

   task automatic seq_bytes(input logic [7:0] first, input int n);
      pkt_q.delete();
      for (int i = 0; i < n; i++) pkt_q.push_back(first + 8'(i));
   endtask

   task automatic wait_drain();
      int cnt;
      cnt = 0;
      while ((exp_hdr_q.size() + exp_pay_q.size() != 0 || m_axis_tvalid || m_hdr_tvalid)
             && cnt < 2000) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk("drain_left", exp_hdr_q.size() + exp_pay_q.size(), 0);
   endtask

   // sink ready generator
   initial forever begin
      @(posedge clk);
      #1;
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      m_hdr_tready  = hdr_block ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
   end

   // compare process
   logic              p_pv = 1'b0, p_pr = 1'b0, p_hv = 1'b0, p_hr = 1'b0;
   logic [W+DW+1:0]   p_pay = '0;
   logic [W+DW:0]     p_hdr = '0;
   logic [W+DW:0]     e_pay;
   logic [W+DW-1:0]   e_hdr;
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         p_pv = 1'b0;
         p_hv = 1'b0;
      end else begin
         if (p_pv && !p_pr)
            chk("pay_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, p_pay);
         if (p_hv && !p_hr)
            chk("hdr_hold", {m_hdr_tvalid, m_hdr_tkeep, m_hdr_tdata}, p_hdr);
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_pay_q.size() == 0) chk("pay_unexpected", exp_pay_q.size(), 1);
            else begin
               e_pay = exp_pay_q.pop_front();
               chk("payload", {m_axis_tlast, m_axis_tkeep, m_axis_tdata & bmask(m_axis_tkeep)}, e_pay);
            end
         end
         if (m_hdr_tvalid && m_hdr_tready) begin
            if (exp_hdr_q.size() == 0) chk("hdr_unexpected", exp_hdr_q.size(), 1);
            else begin
               e_hdr = exp_hdr_q.pop_front();
               chk("header", {m_hdr_tkeep, m_hdr_tdata & bmask(m_hdr_tkeep)}, e_hdr);
            end
         end
`ifdef STRIP_HDR_ERR_EN
         if (err_short_o) got_short++;
`endif
         p_pv  = m_axis_tvalid;
         p_pr  = m_axis_tready;
         p_pay = {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
         p_hv  = m_hdr_tvalid;
         p_hr  = m_hdr_tready;
         p_hdr = {m_hdr_tvalid, m_hdr_tkeep, m_hdr_tdata};
      end
   end

   // main sequence
   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs",
          {s_len_tready, s_axis_tready, m_hdr_tvalid, m_axis_tvalid, m_axis_tlast,
           m_hdr_tkeep, m_axis_tkeep}, 0);
      chk("reset_data", {m_hdr_tdata, m_axis_tdata}, 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("len_ready_idle", {s_len_tready, s_axis_tready}, 2'b10);

      // H=2 over two full beats
      pkt_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h11, 8'h22};
      model_pkt(2);
      chk("pin_t1_hdr",  exp_hdr_q[0], {4'h3, 32'h0000AABB});
      chk("pin_t1_pay0", exp_pay_q[0], {1'b0, 4'hF, 32'hCCDDEEFF});
      chk("pin_t1_pay1", exp_pay_q[1], {1'b1, 4'hC, 32'h11220000});
      drive_pkt(2, 1000);
      wait_drain();

      // H=3, last beat three bytes: payload fits one word
      seq_bytes(8'h01, 7);
      model_pkt(3);
      chk("pin_t2_hdr", exp_hdr_q[0], {4'h7, 32'h00010203});
      chk("pin_t2_pay", exp_pay_q[0], {1'b1, 4'hF, 32'h04050607});
      chk("pin_t2_cnt", exp_pay_q.size(), 1);
      drive_pkt(3, 1000);
      wait_drain();

      // H=1, two full beats: last residual goes out as a separate beat
      seq_bytes(8'h10, 8);
      model_pkt(1);
      chk("pin_t3_pay0", exp_pay_q[0], {1'b0, 4'hF, 32'h11121314});
      chk("pin_t3_pay1", exp_pay_q[1], {1'b1, 4'hE, 32'h15161700});
      drive_pkt(1, 1000);
      wait_drain();

      // H=4: whole first beat is header
      seq_bytes(8'h20, 8);
      model_pkt(4);
      chk("pin_t4_hdr", exp_hdr_q[0], {4'hF, 32'h20212223});
      drive_pkt(4, 1000);
      wait_drain();

      // H=0: bypass, no header
      seq_bytes(8'h30, 7);
      model_pkt(0);
      chk("pin_t5_nohdr", exp_hdr_q.size(), 0);
      chk("pin_t5_pay0", exp_pay_q[0], {1'b0, 4'hF, 32'h30313233});
      drive_pkt(0, 1000);
      wait_drain();

      // short packet: H=3 but only two bytes
      pkt_q = '{8'h40, 8'h41};
      model_pkt(3);
      chk("pin_t6_hdr", exp_hdr_q[0], {4'h3, 32'h00004041});
      chk("pin_t6_nopay", exp_pay_q.size(), 0);
      drive_pkt(3, 1000);
      wait_drain();

      // H=7 saturates to a full beat
      seq_bytes(8'h50, 6);
      run_pkt(7);
      wait_drain();

      // single beat, k>H and k==H
      seq_bytes(8'h60, 4);
      run_pkt(2);
      seq_bytes(8'h70, 2);
      run_pkt(2);
      wait_drain();

      // reset in the middle of a packet with the header stalled
      hdr_block = 1'b1;
      seq_bytes(8'h80, 8);
      drive_pkt(2, 1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("midreset_outputs", {m_hdr_tvalid, m_axis_tvalid, s_len_tready, s_axis_tready}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      hdr_block = 1'b0;
      seq_bytes(8'h90, 9);
      run_pkt(3);
      wait_drain();

      // random packets with random back-pressure
      rand_ready = 1'b1;
      for (int p = 0; p < 200; p++) begin
         int h, n;
         h = $urandom_range(0, 6);
         n = $urandom_range(1, 12);
         pkt_q.delete();
         for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom));
         run_pkt(h);
      end
      wait_drain();
      rand_ready = 1'b0;

`ifdef STRIP_HDR_ERR_EN
      chk("err_pulses", got_short, exp_short);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
